// File: rtl/esn_rx_framer.sv
// Byte-stream to word framer: packs LSB-first bytes into sign/zero-extended words
// tagged with channel/index, with optional s_last frame-boundary checking.
module esn_rx_framer #(
  parameter int BYTES_PER_WORD = 2,
  parameter int OUT_W          = 16,
  parameter int SIGN_EXT       = 1,
  parameter int CHANNELS       = 1,
  parameter int WORDS_PER_CHAN = 40,
  parameter int USE_LAST       = 0,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int IW = (WORDS_PER_CHAN > 1) ? $clog2(WORDS_PER_CHAN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [CW-1:0]    m_chan,
  output logic [IW-1:0]    m_idx,
  output logic             m_frame_last,
  output logic [15:0]      frame_cnt,
  output logic             err_short,
  output logic             err_long
);

  localparam int AW = 8 * BYTES_PER_WORD;
  localparam int BW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [OUT_W-1:0] EXT_MASK = ~OUT_W'({AW{1'b1}});

  typedef enum logic [1:0] {COLLECT, HOLD, DISCARD} state_t;

  state_t           r_state, w_state_next;
  logic [BW-1:0]    r_byte_cnt;
  logic [CW-1:0]    r_chan;
  logic [IW-1:0]    r_idx;
  logic [AW-1:0]    r_accum;
  logic [OUT_W-1:0] r_m_data;
  logic [CW-1:0]    r_m_chan;
  logic [IW-1:0]    r_m_idx;
  logic             r_m_frame_last;
  logic [15:0]      r_frame_cnt;
  logic             r_err_short, r_err_long;
  logic             r_discard_pend;

  logic             w_s_fire, w_byte_last, w_frame_end, w_short, w_long;
  logic [AW-1:0]    w_word;
  logic [OUT_W-1:0] w_ext;

  assign w_s_fire    = s_valid && s_ready;
  assign w_byte_last = (r_byte_cnt == BW'(BYTES_PER_WORD - 1));
  assign w_frame_end = w_byte_last && (r_chan == CW'(CHANNELS - 1)) &&
                       (r_idx == IW'(WORDS_PER_CHAN - 1));
  assign w_short     = (USE_LAST != 0) && s_last && !w_frame_end;
  assign w_long      = (USE_LAST != 0) && !s_last && w_frame_end;

  // The arriving byte is always the top byte of the word being completed.
  always_comb begin
    w_word = r_accum;
    w_word[8*(BYTES_PER_WORD-1) +: 8] = s_data;
    w_ext = OUT_W'(w_word) | (((SIGN_EXT != 0) && w_word[AW-1]) ? EXT_MASK : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= COLLECT;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    case (r_state)
      COLLECT: begin
        s_ready = rst_n;
        if (s_valid && !w_short && w_byte_last) w_state_next = HOLD;
      end
      HOLD: begin
        m_valid = 1'b1;
        if (m_ready) w_state_next = r_discard_pend ? DISCARD : COLLECT;
      end
      DISCARD: begin
        s_ready = rst_n;
        if (s_valid && s_last) w_state_next = COLLECT;
      end
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt     <= '0;
      r_chan         <= '0;
      r_idx          <= '0;
      r_accum        <= '0;
      r_m_data       <= '0;
      r_m_chan       <= '0;
      r_m_idx        <= '0;
      r_m_frame_last <= 1'b0;
      r_frame_cnt    <= '0;
      r_err_short    <= 1'b0;
      r_err_long     <= 1'b0;
      r_discard_pend <= 1'b0;
    end else begin
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      if (r_state == COLLECT && w_s_fire) begin
        if (w_short) begin
          r_byte_cnt  <= '0;
          r_chan      <= '0;
          r_idx       <= '0;
          r_err_short <= 1'b1;
        end else if (!w_byte_last) begin
          r_accum[8*r_byte_cnt +: 8] <= s_data;
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end else begin
          r_m_data       <= w_ext;
          r_m_chan       <= r_chan;
          r_m_idx        <= r_idx;
          r_m_frame_last <= w_frame_end;
          r_byte_cnt     <= '0;
          // Position advances now; the word in HOLD is already committed.
          if (w_frame_end) begin
            r_chan         <= '0;
            r_idx          <= '0;
            r_discard_pend <= w_long;
            r_err_long     <= w_long;
          end else if (r_chan == CW'(CHANNELS - 1)) begin
            r_chan <= '0;
            r_idx  <= r_idx + 1'b1;
          end else begin
            r_chan <= r_chan + 1'b1;
          end
        end
      end else if (r_state == HOLD && m_ready) begin
        r_discard_pend <= 1'b0;
        if (r_m_frame_last) r_frame_cnt <= r_frame_cnt + 16'd1;
      end else if (r_state == DISCARD && w_s_fire && s_last) begin
        r_byte_cnt <= '0;
        r_chan     <= '0;
        r_idx      <= '0;
      end
    end
  end

  assign m_data       = r_m_data;
  assign m_chan       = r_m_chan;
  assign m_idx        = r_m_idx;
  assign m_frame_last = r_m_frame_last;
  assign frame_cnt    = r_frame_cnt;
  assign err_short    = r_err_short;
  assign err_long     = r_err_long;

endmodule

// File: doc/esn_rx_framer.md
ESN_RX_FRAMER -- requirements
Module: esn_rx_framer

Interface
REQ-001 Parameter BYTES_PER_WORD, default 2, bytes per sample word, 1..4, LSB byte first.
REQ-002 Parameter OUT_W, default 16, output word width, >= 8*BYTES_PER_WORD, <= 32.
REQ-003 Parameter SIGN_EXT, default 1, 1 = sign-extend to OUT_W, 0 = zero-extend.
REQ-004 Parameter CHANNELS, default 1, interleaved channels per frame, 1..8.
REQ-005 Parameter WORDS_PER_CHAN, default 40, words per channel per frame, 1..1024.
REQ-006 Parameter USE_LAST, default 0, 1 = frame boundaries checked against s_last.
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 rst_n  in  1  reset; asynchronous, active-low.
REQ-009 s_valid / s_ready / s_data / s_last  in / out / in / in  1 / 1 / 8 / 1  byte stream from RX FIFO.
REQ-010 m_valid / m_ready / m_data  out / in / out  1 / 1 / OUT_W  assembled word stream.
REQ-011 m_chan  out  clog2(CHANNELS) (min 1)  channel of m_data.
REQ-012 m_idx  out  clog2(WORDS_PER_CHAN) (min 1)  per-channel word index.
REQ-013 m_frame_last  out  1  high with last word of frame.
REQ-014 frame_cnt  out  16  completed good frames, wraps 0xFFFF->0.
REQ-015 err_short / err_long  out / out  1 / 1  one-cycle error pulses.

Function
REQ-016 Byte accepted only when s_valid && s_ready at rising clk.
REQ-017 States: COLLECT (s_ready=1, m_valid=0), HOLD (s_ready=0, m_valid=1), DISCARD (s_ready=1, m_valid=0).
REQ-018 COLLECT: byte k of word (k=0..BYTES_PER_WORD-1) stored in bits [8k+7:8k]; on acceptance of final byte -> HOLD next cycle.
REQ-019 Latency: m_valid high on the cycle after final byte of word accepted; peak throughput one word per BYTES_PER_WORD+1 cycles.
REQ-020 HOLD: m_data, m_chan, m_idx, m_frame_last stable until m_valid && m_ready; then -> COLLECT.
REQ-021 Word order within frame: channel fastest; word n -> m_chan = n mod CHANNELS, m_idx = n div CHANNELS; frame = CHANNELS*WORDS_PER_CHAN words.
REQ-022 m_frame_last = 1 only for word n = CHANNELS*WORDS_PER_CHAN-1; frame_cnt increments on its handshake; counters return to 0.
REQ-023 USE_LAST=0: s_last ignored; frames delimited purely by count.
REQ-024 USE_LAST=1, s_last on a byte not final byte of frame: byte dropped, partial word and partial frame discarded, err_short pulses next cycle, counters to 0, stay COLLECT, frame_cnt unchanged.
REQ-025 USE_LAST=1, final byte of frame without s_last: word still delivered, frame_cnt increments, err_long pulses; after HOLD -> DISCARD.
REQ-026 DISCARD: bytes accepted and dropped until byte with s_last accepted, then -> COLLECT with counters 0.
REQ-027 Words already in HOLD are never cancelled by any error.
REQ-028 s_valid low mid-word: partial bytes retained indefinitely, no timeout.

Reset
REQ-029 rst_n low asynchronously forces: state COLLECT, s_ready=1 after release, m_valid=0, m_data=0, m_chan=0, m_idx=0, m_frame_last=0, frame_cnt=0, err_short=0, err_long=0, byte/word counters 0.
REQ-030 Reset mid-word or mid-HOLD drops pending data; first byte after release is byte 0 of word 0.
REQ-031 During rst_n low s_ready=0.

Verification
REQ-032 Defaults, 80 bytes 0x34,0x12,... continuous, m_ready=1 -> 40 words, first m_data 0x1234, m_frame_last on word 39 only, frame_cnt=1.
REQ-033 BYTES_PER_WORD=2, OUT_W=32, SIGN_EXT=1, bytes 0x00,0x80 -> m_data 0xFFFF8000; SIGN_EXT=0 -> 0x00008000.
REQ-034 CHANNELS=4, WORDS_PER_CHAN=2, 16 bytes -> m_chan sequence 0,1,2,3,0,1,2,3, m_idx 0,0,0,0,1,1,1,1.
REQ-035 USE_LAST=1, s_last on byte 10 of 80 -> no word 5 emitted, err_short one pulse, next 80-byte frame delivered intact, frame_cnt=1.
REQ-036 USE_LAST=1, 84 bytes with s_last on byte 83 -> 40 words, err_long one pulse, 4 trailing bytes dropped, next frame starts at m_idx 0.
REQ-037 m_ready held low 20 cycles during HOLD -> s_ready=0, m_data stable; random s_valid/m_ready gaps -> output identical to REQ-032; rst_n pulse mid-word -> m_valid=0 immediately, clean restart.
